// File: rtl/vga_text_buffer.sv
// Character/colour text buffer with a writer-side cursor, a registered renderer
// read port, and clear sweeps at reset and on every row advance.
module vga_text_buffer #(
    parameter int COLS  = 40,
    parameter int ROWS  = 15,
    parameter int COL_W = 6,
    parameter int ROW_W = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [1:0]       COMMAND,
    input  logic [7:0]       ASCII_IN,
    input  logic [7:0]       COLOR_IN,
    input  logic [COL_W-1:0] RD_COL,
    input  logic [ROW_W-1:0] RD_ROW,
    output logic [7:0]       RD_CHAR,
    output logic [7:0]       RD_COLOR,
    output logic [COL_W-1:0] CURSOR_COL,
    output logic [ROW_W-1:0] CURSOR_ROW,
    output logic             BUSY,
    output logic             OVERFLOW
);

    localparam int          CELLS = ROWS * COLS;
    localparam int          AW    = $clog2(CELLS);
    localparam logic [15:0] BLANK = 16'h00FF;

    typedef enum logic [1:0] {INIT_CLEAR, IDLE, ROW_CLEAR} state_t;
    typedef enum logic [1:0] {CMD_DISP = 2'b00, CMD_DEL = 2'b01,
                              CMD_NL = 2'b10, CMD_NULL = 2'b11} cmd_t;

    function automatic logic [AW-1:0] addr_of(input logic [ROW_W-1:0] r,
                                               input logic [COL_W-1:0] c);
        return AW'(r) * AW'(COLS) + AW'(c);
    endfunction

    logic [15:0]      mem [CELLS];
    logic [15:0]      rd_q;

    state_t           state_q, state_d;
    logic [AW-1:0]    sweep_q, sweep_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             pv_q, pv_d;
    cmd_t             pc_q, pc_d;
    logic [7:0]       pch_q, pch_d;
    logic [7:0]       pco_q, pco_d;
    logic             ovf_q, ovf_d;

    logic             we;
    logic [AW-1:0]    waddr;
    logic [15:0]      wdata;
    logic             live_v;
    cmd_t             ex_cmd;
    logic [7:0]       ex_ch;
    logic [7:0]       ex_co;
    logic [ROW_W-1:0] next_row;

    assign live_v   = (cmd_t'(COMMAND) != CMD_NULL);
    assign next_row = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + ROW_W'(1);

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        col_d   = col_q;
        row_d   = row_q;
        pv_d    = pv_q;
        pc_d    = pc_q;
        pch_d   = pch_q;
        pco_d   = pco_q;
        ovf_d   = ovf_q;
        we      = 1'b0;
        waddr   = sweep_q;
        wdata   = BLANK;
        ex_cmd  = CMD_NULL;
        ex_ch   = '0;
        ex_co   = '0;

        case (state_q)
            INIT_CLEAR: begin
                we    = 1'b1;
                waddr = sweep_q;
                if (sweep_q == AW'(CELLS - 1)) begin
                    state_d = IDLE;
                    sweep_d = '0;
                end else begin
                    sweep_d = sweep_q + AW'(1);
                end
            end
            ROW_CLEAR: begin
                we    = 1'b1;
                waddr = addr_of(row_q, COL_W'(sweep_q));
                if (sweep_q == AW'(COLS - 1)) begin
                    state_d = IDLE;
                    sweep_d = '0;
                end else begin
                    sweep_d = sweep_q + AW'(1);
                end
            end
            default: begin
                // Pending command wins; the live one takes over the freed slot.
                if (pv_q) begin
                    ex_cmd = pc_q;
                    ex_ch  = pch_q;
                    ex_co  = pco_q;
                    pv_d   = live_v;
                    pc_d   = cmd_t'(COMMAND);
                    pch_d  = ASCII_IN;
                    pco_d  = COLOR_IN;
                end else begin
                    ex_cmd = cmd_t'(COMMAND);
                    ex_ch  = ASCII_IN;
                    ex_co  = COLOR_IN;
                end
            end
        endcase

        if (state_q != IDLE && live_v) begin
            if (!pv_q) begin
                pv_d  = 1'b1;
                pc_d  = cmd_t'(COMMAND);
                pch_d = ASCII_IN;
                pco_d = COLOR_IN;
            end else begin
                ovf_d = 1'b1;
            end
        end

        case (ex_cmd)
            CMD_DISP: begin
                we    = 1'b1;
                waddr = addr_of(row_q, col_q);
                wdata = {ex_ch, ex_co};
                if (col_q < COL_W'(COLS - 1)) begin
                    col_d = col_q + COL_W'(1);
                end else begin
                    col_d   = '0;
                    row_d   = next_row;
                    state_d = ROW_CLEAR;
                    sweep_d = '0;
                end
            end
            CMD_DEL: begin
                if (col_q != '0) begin
                    col_d = col_q - COL_W'(1);
                    we    = 1'b1;
                    waddr = addr_of(row_q, col_q - COL_W'(1));
                end else if (row_q != '0) begin
                    col_d = COL_W'(COLS - 1);
                    row_d = row_q - ROW_W'(1);
                    we    = 1'b1;
                    waddr = addr_of(row_q - ROW_W'(1), COL_W'(COLS - 1));
                end
            end
            CMD_NL: begin
                col_d   = '0;
                row_d   = next_row;
                state_d = ROW_CLEAR;
                sweep_d = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= INIT_CLEAR;
            sweep_q <= '0;
            col_q   <= '0;
            row_q   <= '0;
            pv_q    <= 1'b0;
            pc_q    <= CMD_NULL;
            pch_q   <= '0;
            pco_q   <= '0;
            ovf_q   <= 1'b0;
            rd_q    <= BLANK;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            col_q   <= col_d;
            row_q   <= row_d;
            pv_q    <= pv_d;
            pc_q    <= pc_d;
            pch_q   <= pch_d;
            pco_q   <= pco_d;
            ovf_q   <= ovf_d;
            rd_q    <= mem[addr_of(RD_ROW, RD_COL)];
        end
    end

    always_ff @(posedge CLK) begin
        if (we && !RST) begin
            mem[waddr] <= wdata;
        end
    end

    assign RD_CHAR    = rd_q[15:8];
    assign RD_COLOR   = rd_q[7:0];
    assign CURSOR_COL = col_q;
    assign CURSOR_ROW = row_q;
    assign BUSY       = (state_q != IDLE);
    assign OVERFLOW   = ovf_q;

endmodule
